// File: rtl/eq_sample_sequencer.sv
// Sample-rate stimulus/check sequencer for equalizer bring-up and BIST.
// Optional first-mismatch capture ports: define EQ_SEQ_FIRST_ERR_EN.
module eq_sample_sequencer #(
   parameter int DATA_BITS   = 16,
   parameter int ADDR_BITS   = 20,
   parameter int NUM_SAMPLES = 3000,
   parameter int DIV         = 64,
   parameter int LATENCY     = 64,
   parameter int START_DELAY = 20
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   output logic [ADDR_BITS-1:0] src_addr,
   input  logic [DATA_BITS-1:0] src_data,
   output logic [ADDR_BITS-1:0] ref_addr,
   input  logic [DATA_BITS-1:0] ref_data,
   output logic                 dut_ce,
   output logic [DATA_BITS-1:0] dut_in,
   input  logic [DATA_BITS-1:0] dut_out,
   output logic                 sample_stb,
   output logic                 check_stb,
   output logic [31:0]          err_cnt,
   output logic                 busy,
   output logic                 done,
   output logic                 pass
`ifdef EQ_SEQ_FIRST_ERR_EN
   ,
   output logic                 first_err_valid,
   output logic [ADDR_BITS-1:0] first_err_idx,
   output logic [DATA_BITS-1:0] first_err_got,
   output logic [DATA_BITS-1:0] first_err_exp
`endif
);

   localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;

   localparam logic [DW-1:0]        DIV_LAST  = DW'(DIV - 1);
   localparam logic [7:0]           WARM_LAST = 8'(START_DELAY - 1);
   localparam logic [ADDR_BITS-1:0] LAST_IDX  = ADDR_BITS'(NUM_SAMPLES - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WARM,
      S_RUN,
      S_DRAIN,
      S_DONE
   } state_t;

   state_t             state;
   logic [DW-1:0]      div_cnt;
   logic [7:0]         warm_cnt;
   logic [LATENCY-1:0] dly;

   logic        fire;
   logic        mism;
   logic        last_src;
   logic        last_chk;
   logic [31:0] err_nxt;

   assign check_stb = dly[LATENCY-1];

   always_comb begin
      fire     = 1'b0;
      last_src = (src_addr == LAST_IDX);
      mism     = (dut_out != ref_data);
      last_chk = check_stb && (ref_addr == LAST_IDX);
      err_nxt  = err_cnt;
      if (state == S_WARM && warm_cnt == WARM_LAST)
         fire = 1'b1;
      if (state == S_RUN && div_cnt == DIV_LAST)
         fire = 1'b1;
      if (check_stb && mism && err_cnt != 32'hFFFF_FFFF)
         err_nxt = err_cnt + 32'd1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_IDLE;
         div_cnt    <= '0;
         warm_cnt   <= '0;
         dly        <= '0;
         src_addr   <= '0;
         ref_addr   <= '0;
         dut_in     <= '0;
         dut_ce     <= 1'b0;
         sample_stb <= 1'b0;
         err_cnt    <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         pass       <= 1'b0;
`ifdef EQ_SEQ_FIRST_ERR_EN
         first_err_valid <= 1'b0;
         first_err_idx   <= '0;
         first_err_got   <= '0;
         first_err_exp   <= '0;
`endif
      end else begin
         sample_stb <= 1'b0;

         if (busy) begin
            dly[0] <= sample_stb;
            for (int i = 1; i < LATENCY; i++)
               dly[i] <= dly[i-1];
         end

         if (check_stb) begin
            err_cnt  <= err_nxt;
            ref_addr <= ref_addr + 1'b1;
`ifdef EQ_SEQ_FIRST_ERR_EN
            if (mism && !first_err_valid) begin
               first_err_valid <= 1'b1;
               first_err_idx   <= ref_addr;
               first_err_got   <= dut_out;
               first_err_exp   <= ref_data;
            end
`endif
         end

         // The strobe is registered so dut_in changes on the same edge.
         if (fire) begin
            sample_stb <= 1'b1;
            dut_in     <= src_data;
            src_addr   <= src_addr + 1'b1;
            div_cnt    <= '0;
         end else if (state == S_RUN) begin
            div_cnt <= div_cnt + 1'b1;
         end

         unique case (state)
            S_IDLE, S_DONE: begin
               if (start) begin
                  state    <= S_WARM;
                  busy     <= 1'b1;
                  dut_ce   <= 1'b1;
                  done     <= 1'b0;
                  pass     <= 1'b0;
                  warm_cnt <= '0;
                  div_cnt  <= '0;
                  dly      <= '0;
                  src_addr <= '0;
                  ref_addr <= '0;
                  err_cnt  <= '0;
`ifdef EQ_SEQ_FIRST_ERR_EN
                  first_err_valid <= 1'b0;
                  first_err_idx   <= '0;
                  first_err_got   <= '0;
                  first_err_exp   <= '0;
`endif
               end
            end
            S_WARM: begin
               warm_cnt <= warm_cnt + 1'b1;
               if (fire)
                  state <= last_src ? S_DRAIN : S_RUN;
            end
            S_RUN: begin
               if (fire && last_src)
                  state <= S_DRAIN;
            end
            S_DRAIN: begin
               if (last_chk) begin
                  state  <= S_DONE;
                  busy   <= 1'b0;
                  dut_ce <= 1'b0;
                  done   <= 1'b1;
                  pass   <= (err_nxt == 32'd0);
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: doc/eq_sample_sequencer.md
Name: eq_sample_sequencer

Overview:
Synthesisable, parametrised sample-stream sequencer for equalizer bring-up and BIST. Divides the system clock into a sample-rate strobe and feeds stimulus samples from a source memory to the DUT. Delays each strobe by the DUT's pipeline latency, then compares the DUT output against a reference memory. Reports error count, pass and done. Sits between the equalizer core and two sample memories (stimulus, expected).

Parameters:
DATA_BITS, 16, sample width (signed two's complement) for stimulus, DUT output and reference.
ADDR_BITS, 20, width of source and reference address buses.
NUM_SAMPLES, 3000, samples per run; 1..2^ADDR_BITS-1.
DIV, 64, clocks per sample strobe; 2..1024.
LATENCY, 64, clocks from a sample strobe to the matching check strobe; 1..255.
START_DELAY, 20, warm-up clocks after start before the first strobe; 1..255.

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
start  in  1  one-clock run request; honoured only in IDLE or DONE
src_addr  out  ADDR_BITS  stimulus memory address (index of next sample)
src_data  in  DATA_BITS  stimulus word; combinational (async-read) memory
ref_addr  out  ADDR_BITS  reference memory address (index of next check)
ref_data  in  DATA_BITS  expected word; combinational memory
dut_ce  out  1  DUT clock enable
dut_in  out  DATA_BITS  sample to DUT, held between strobes
dut_out  in  DATA_BITS  DUT output
sample_stb  out  1  one-clock strobe; dut_in updates on this edge
check_stb  out  1  sample_stb delayed LATENCY clocks; compare cycle
err_cnt  out  32  mismatch count, saturating at 2^32-1
busy  out  1  high in WARMUP, RUN, DRAIN
done  out  1  high in DONE
pass  out  1  done && err_cnt==0

Behaviour:
- Reset (synchronous, rst=1 at a clk edge): state=IDLE. All outputs 0, including dut_in, addresses, err_cnt, strobes and the delay line. Reset mid-run aborts immediately, with no completion report.
- States:
  - IDLE: start → WARMUP.
  - WARMUP: counts START_DELAY clocks → RUN.
  - RUN: issues strobes until NUM_SAMPLES have been issued → DRAIN.
  - DRAIN: waits until NUM_SAMPLES checks are done → DONE.
  - DONE: start → WARMUP.
- start behaviour:
  - On accept (IDLE or DONE): clear src_addr, ref_addr, err_cnt, divider and delay line.
  - start while busy is ignored.
- dut_ce: 1 in WARMUP, RUN, DRAIN; 0 in IDLE and DONE.
- Divider: reset to 0 on entry to RUN; sample_stb=1 when divider==0 in RUN; divider wraps at DIV-1. First strobe occurs on the first RUN cycle; subsequent strobes every DIV clocks.
- On a sample_stb edge: dut_in <= src_data; src_addr <= src_addr+1. In all other cycles dut_in holds its value.
- After the NUM_SAMPLES-th strobe: no further strobes; src_addr stays at NUM_SAMPLES; state → DRAIN on the same edge.
- Delay line: LATENCY-bit shift register advanced every clock while busy; check_stb = last stage.
- On check_stb:
  - mismatch = (dut_out != ref_data), compared combinationally in that cycle.
  - err_cnt increments on mismatch (saturating).
  - ref_addr increments.
- The NUM_SAMPLES-th check moves the state to DONE on the same edge. A check_stb coinciding with the last sample_stb (LATENCY multiple of DIV) is processed normally.
- DONE: busy=0, done=1, pass registered from err_cnt; outputs held until start or rst.
- Run length in clocks from start accept to done: START_DELAY + (NUM_SAMPLES-1)*DIV + LATENCY + 1.

Optional Feature:
Macro EQ_SEQ_FIRST_ERR_EN.
- Defined: adds outputs first_err_valid (1), first_err_idx (ADDR_BITS), first_err_got (DATA_BITS) and first_err_exp (DATA_BITS). These latch ref_addr, dut_out and ref_data on the first mismatch of a run. They are cleared by rst or an accepted start.
- Undefined: these ports and registers do not exist; all other behaviour is identical.

Test Plan:
1. NUM_SAMPLES=4, DIV=4, LATENCY=6, START_DELAY=3; src={1,2,3,4}; DUT modelled as a 6-clock delay; ref={1,2,3,4} → 4 sample_stb spaced 4 clocks; dut_in sequence 1,2,3,4; done at 3+12+6+1=22 clocks after start; err_cnt=0; pass=1.
2. Same setup, ref[2]=99 → err_cnt=1, pass=0; with EQ_SEQ_FIRST_ERR_EN: first_err_idx=2, first_err_got=3, first_err_exp=99.
3. start pulsed again at clock 10 of a run → ignored; run completes at clock 22; src_addr never exceeds 4.
4. rst asserted during RUN after the 2nd strobe → next clock: IDLE, all outputs 0, dut_ce=0; no done; a new start runs cleanly to pass=1.
5. LATENCY=8, DIV=4 (check coincides with a later strobe) → both processed in the same cycle; err_cnt=0; 4 checks total.
6. Error saturation: err_cnt preloaded near its maximum via a force in the bench, all samples mismatching → err_cnt sticks at 0xFFFFFFFF.
